// File: rtl/screen_rx_oversample.sv
// 16x oversampling 8-bit LSB-first UART receiver with 3-sample majority vote.
// Optional even parity bit after D7 when SCREEN_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for synced rx 1->0 edge
// START  | validating start bit, glitch returns to IDLE
// DATA   | shifting in D0..D7
// PARITY | capturing parity bit (SCREEN_RX_PARITY_EN only)
// STOP   | sampling stop bit, delivers byte at mid-bit
module screen_rx_oversample #(
    parameter int OVS     = 16,
    parameter int SYNC_FF = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic [15:0] bps_num,
    output logic [7:0]  data_out,
    output logic        data_rx_flash,
    output logic        frame_err,
    output logic        parity_err,
    output logic        rx_busy
);

    localparam logic [3:0] OV_LAST = 4'(OVS - 1);
    localparam logic [3:0] OV_S0   = 4'(OVS / 2 - 1);
    localparam logic [3:0] OV_S1   = 4'(OVS / 2);
    localparam logic [3:0] OV_S2   = 4'(OVS / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SCREEN_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state;
    logic [SYNC_FF-1:0]  sync_q;
    logic                rx_s;
    logic                rx_prev;
    logic                start_edge;
    logic [15:0]         bps_num_q;
    logic [15:0]         div_cnt;
    logic [3:0]          ov_cnt;
    logic                tick;
    logic [2:0]          smp;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                maj_bit;
    logic                maj_stop;
`ifdef SCREEN_RX_PARITY_EN
    logic                par_q;
`endif

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign rx_s       = sync_q[SYNC_FF-1];
    assign start_edge = rx_prev & ~rx_s;
    assign tick       = (div_cnt == bps_num_q);
    assign maj_bit    = maj3(smp[0], smp[1], smp[2]);
    // Stop decision is made on the third sample tick, so the live value is the third vote.
    assign maj_stop   = maj3(smp[0], smp[1], rx_s);

    // Preset to idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_FF-2:0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bps_num_q     <= '0;
            div_cnt       <= '0;
            ov_cnt        <= '0;
            smp           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            data_out      <= '0;
            data_rx_flash <= 1'b0;
            frame_err     <= 1'b0;
            parity_err    <= 1'b0;
            rx_busy       <= 1'b0;
`ifdef SCREEN_RX_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            data_rx_flash <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                if (tick) begin
                    ov_cnt <= ov_cnt + 4'd1;
                    if (ov_cnt == OV_S0) smp[0] <= rx_s;
                    if (ov_cnt == OV_S1) smp[1] <= rx_s;
                    if (ov_cnt == OV_S2) smp[2] <= rx_s;
                end
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= START;
                        rx_busy   <= 1'b1;
                        bps_num_q <= bps_num;
                        div_cnt   <= '0;
                        ov_cnt    <= '0;
                    end
                end
                START: begin
                    if (tick && ov_cnt == OV_LAST) begin
                        if (!maj_bit) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick && ov_cnt == OV_LAST) begin
                        shreg   <= {maj_bit, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef SCREEN_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef SCREEN_RX_PARITY_EN
                PARITY: begin
                    if (tick && ov_cnt == OV_LAST) begin
                        par_q <= maj_bit;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick && ov_cnt == OV_S2) begin
                        data_out      <= shreg;
                        frame_err     <= ~maj_stop;
`ifdef SCREEN_RX_PARITY_EN
                        parity_err    <= ^{shreg, par_q};
`endif
                        data_rx_flash <= 1'b1;
                        state         <= IDLE;
                        rx_busy       <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_rx_oversample.sv
// Scoreboard bench for screen_rx_oversample: frames push expected results, strobes pop them.
// Honors SCREEN_RX_PARITY_EN to add the parity bit and parity checks.
module tb_screen_rx_oversample;

    localparam int BPS = 15;
    localparam int BIT = 16 * (BPS + 1);

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] bps_num = 16'(BPS);
    logic [7:0]  data_out;
    logic        data_rx_flash;
    logic        frame_err;
    logic        parity_err;
    logic        rx_busy;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    screen_rx_oversample #(.OVS(16), .SYNC_FF(2)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .bps_num(bps_num),
        .data_out(data_out), .data_rx_flash(data_rx_flash), .frame_err(frame_err),
        .parity_err(parity_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe pops the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && data_rx_flash === 1'b1) begin
            exp_t e;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe data_out=%h frame_err=%b", data_out, frame_err);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.d || frame_err !== e.fe || parity_err !== e.pe) begin
                    tests_failed++;
                    $display("FAIL strobe_result got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b",
                             data_out, frame_err, parity_err, e.d, e.fe, e.pe);
                end
            end
        end
    end

    task automatic drive_bit(input logic v, input int clks);
        uart_rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
`ifdef SCREEN_RX_PARITY_EN
        e.pe = ^{d, par};
`else
        e.pe = 1'b0;
`endif
        exp_q.push_back(e);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef SCREEN_RX_PARITY_EN
        drive_bit(par, BIT);
`endif
        drive_bit(stop, BIT);
    endtask

    task automatic test_reset;
        tests_run++;
        if ({data_out, data_rx_flash, frame_err, parity_err, rx_busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs got d=%h fl=%b fe=%b pe=%b busy=%b want all 0",
                     data_out, data_rx_flash, frame_err, parity_err, rx_busy);
        end
    endtask

    task automatic test_single;
        send_frame(8'h55, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL single_0x55_timeout pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_after got %b want 0", rx_busy);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL back_to_back_missing pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_frame_err;
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 3 * BIT);
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_busy got %b want 0", rx_busy);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL frame_err_missing pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        drive_bit(1'b1, BIT);
        send_frame(8'h5A, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL recover_after_break pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch;
        int waited;
        drive_bit(1'b0, 100);
        uart_rx = 1'b1;
        tests_run++;
        if (rx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_busy_high got %b want 1", rx_busy);
        end
        waited = 0;
        while (rx_busy === 1'b1 && waited < 2500) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy_release got %b want 0 after %0d clk", rx_busy, waited);
        end
        drive_bit(1'b1, BIT);
        tests_run++;
        if (data_out !== 8'h5A || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_outputs_held got d=%h fe=%b want d=5a fe=0", data_out, frame_err);
        end
    endtask

    task automatic test_reset_mid;
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, 4 * BIT + BIT / 2);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rx_busy !== 1'b0 || data_out !== 8'h00 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear got busy=%b d=%h fe=%b want 0 00 0",
                     rx_busy, data_out, frame_err);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 5 * BIT);
        send_frame(8'h81, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_0x81 pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_parity;
`ifdef SCREEN_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, BIT);
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL parity_frames pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
`else
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, BIT);
        tests_run++;
        if (parity_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_tied_low got %b want 0", parity_err);
        end
`endif
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_frame_err;
        test_glitch;
        test_reset_mid;
        test_parity;
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
